stack_req_arbiter: RTL and testbench

Shares one stack command/response port among `N` independent requesters.
- Grants one requester at a time: round-robin by default, fixed priority when configured.
- Issues the winner's PUSH/POP on the downstream stack channel.
- Routes the stack's response back to the requester that issued it.
- Sits between client agents and the stack datapath; one transaction is outstanding at a time.

---
 rtl/stack_req_arbiter.sv | 172 +++++++++++++++++
 tb/tb_stack_req_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_req_arbiter.sv
// stack_req_arbiter: shares one stack command/response channel among N requesters.
// One transaction is outstanding at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Arbitration is round-robin by default. Defining STACK_ARB_FIXED_PRIO_EN selects fixed
// priority (lowest eligible index wins) and removes the round-robin pointer.
module stack_req_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_valid,
    output logic [N-1:0]         req_ready,
    input  logic [2*N-1:0]       req_cmd,
    input  logic [N*DW-1:0]      req_data,
    output logic [N-1:0]         rsp_valid,
    input  logic [N-1:0]         rsp_ready,
    output logic [2*N-1:0]       rsp_cmd,
    output logic [N*DW-1:0]      rsp_data,
    output logic                 stk_valid,
    input  logic                 stk_ready,
    output logic [1:0]           stk_cmd,
    output logic [DW-1:0]        stk_data,
    input  logic                 stk_rsp_valid,
    output logic                 stk_rsp_ready,
    input  logic [1:0]           stk_rsp_cmd,
    input  logic [DW-1:0]        stk_rsp_data,
    output logic                 busy,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 rsp_err
);
    localparam int unsigned IW = $clog2(N);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] grant_q;
    logic [1:0]    cmd_q, rcmd_q;
    logic [DW-1:0] data_q, rdata_q;
    logic          err_q;

    logic [N-1:0]  elig;
    logic          win_found;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] rr_start;
    logic [1:0]    win_cmd;
    logic [DW-1:0] win_data;
    int unsigned   scan_idx;
    logic          accept;
    logic          rsp_done;

    assign accept   = (state_q == StIdle) && win_found;
    assign rsp_done = (state_q == StResp) && rsp_ready[grant_q];

`ifdef STACK_ARB_FIXED_PRIO_EN
    assign rr_start = '0;
`else
    logic [IW-1:0] rr_ptr_q;

    // Round-robin pointer: moves one past the requester whose response was just taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else if (rsp_done) begin
            rr_ptr_q <= (grant_q == IW'(N - 1)) ? '0 : grant_q + IW'(1);
        end
    end

    assign rr_start = rr_ptr_q;
`endif

    // Eligibility and winner: first valid PUSH/POP at or after rr_start, with wrap.
    always_comb begin
        elig      = '0;
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int unsigned i = 0; i < N; i++) begin
            elig[i] = req_valid[i] & ~req_cmd[2*i+1];
        end
        for (int unsigned k = 0; k < N; k++) begin
            scan_idx = (32'(rr_start) + k) % N;
            if (!win_found && elig[scan_idx[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_idx[IW-1:0];
            end
        end
    end

    // Select the winner's command and data slice for latching.
    always_comb begin
        win_cmd  = '0;
        win_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (IW'(i) == win_idx) begin
                win_cmd  = req_cmd[2*i +: 2];
                win_data = req_data[DW*i +: DW];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (win_found)     state_d = StIssue;
            StIssue: if (stk_ready)     state_d = StWait;
            StWait:  if (stk_rsp_valid) state_d = StResp;
            StResp:  if (rsp_done)      state_d = StIdle;
            default:                    state_d = StIdle;
        endcase
    end

    // Transaction registers: request on accept, response on stack handshake, error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= '0;
            cmd_q   <= '0;
            data_q  <= '0;
            rcmd_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                grant_q <= win_idx;
                cmd_q   <= win_cmd;
                data_q  <= win_data;
            end
            if ((state_q == StWait) && stk_rsp_valid) begin
                rcmd_q  <= stk_rsp_cmd;
                rdata_q <= stk_rsp_data;
            end
            // Expected response is {1, issued_cmd[0]}; mismatches are flagged but forwarded.
            err_q <= (state_q == StWait) && stk_rsp_valid &&
                     (stk_rsp_cmd != {1'b1, cmd_q[0]});
        end
    end

    // Outputs decoded from state and latched values; req_ready is held low during reset.
    always_comb begin
        req_ready     = '0;
        rsp_valid     = '0;
        rsp_cmd       = '0;
        rsp_data      = '0;
        stk_valid     = (state_q == StIssue);
        stk_cmd       = stk_valid ? cmd_q : 2'b00;
        stk_data      = stk_valid ? data_q : '0;
        stk_rsp_ready = (state_q == StWait);
        busy          = (state_q != StIdle);
        grant_id      = grant_q;
        rsp_err       = err_q;
        if (accept && rst_n) begin
            req_ready[win_idx] = 1'b1;
        end
        for (int unsigned i = 0; i < N; i++) begin
            if ((state_q == StResp) && (IW'(i) == grant_q)) begin
                rsp_valid[i]          = 1'b1;
                rsp_cmd[2*i +: 2]     = rcmd_q;
                rsp_data[DW*i +: DW]  = rdata_q;
            end
        end
    end

endmodule

// File: tb/tb_stack_req_arbiter.sv
// Self-checking bench for stack_req_arbiter: directed table, hand-written reset sequence,
// and randomized transactions checked against a transaction-level arbitration model.
module tb_stack_req_arbiter;
    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int IW  = $clog2(N);
    localparam int CW  = 2 * N;
    localparam int DWN = N * DW;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [CW-1:0]  req_cmd, rsp_cmd;
    logic [DWN-1:0] req_data, rsp_data;
    logic           stk_valid, stk_ready, stk_rsp_valid, stk_rsp_ready;
    logic [1:0]     stk_cmd, stk_rsp_cmd;
    logic [DW-1:0]  stk_data, stk_rsp_data;
    logic           busy, rsp_err;
    logic [IW-1:0]  grant_id;

    stack_req_arbiter #(.N(N), .DW(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_cmd       (req_cmd),
        .req_data      (req_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_cmd       (rsp_cmd),
        .rsp_data      (rsp_data),
        .stk_valid     (stk_valid),
        .stk_ready     (stk_ready),
        .stk_cmd       (stk_cmd),
        .stk_data      (stk_data),
        .stk_rsp_valid (stk_rsp_valid),
        .stk_rsp_ready (stk_rsp_ready),
        .stk_rsp_cmd   (stk_rsp_cmd),
        .stk_rsp_data  (stk_rsp_data),
        .busy          (busy),
        .grant_id      (grant_id),
        .rsp_err       (rsp_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ptr    = 0;  // model's round-robin start index

    typedef struct {
        logic [N-1:0]   v;
        logic [CW-1:0]  c;
        logic [DWN-1:0] d;
        int             g_rr;
        int             g_fp;
        int             s_stk;
        int             dly;
        int             s_rsp;
        bit             bad;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    // First requester with valid and cmd 00/01, scanning upward from p with wrap.
    function automatic int model_winner(input logic [N-1:0] v, input logic [CW-1:0] c,
                                        input int p);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (v[j] && (c[2*j+1] == 1'b0)) return j;
        end
        return -1;
    endfunction

    // Full transaction starting in IDLE at a negedge; ends in IDLE at a negedge.
    task automatic do_txn(input logic [N-1:0] v, input logic [CW-1:0] c,
                          input logic [DWN-1:0] d, input int g, input int s_stk,
                          input int dly, input int s_rsp, input bit bad);
        logic [1:0]     icmd, rcmd;
        logic [DW-1:0]  idata, rdata;
        logic [CW-1:0]  exp_rc;
        logic [DWN-1:0] exp_rd;
        logic [N-1:0]   rr;
        req_valid = v;
        req_cmd   = c;
        req_data  = d;
        #1;
        chk("idle_req_ready", 64'(req_ready), 64'(onehot(g)));
        chk("idle_busy", 64'(busy), 64'(0));
        cyc();
        icmd  = c[2*g +: 2];
        idata = d[DW*g +: DW];
        // Everyone else keeps requesting; none may be granted mid-transaction.
        req_valid = '1;
        req_cmd   = '0;
        for (int k = 0; k <= s_stk; k++) begin
            stk_ready = (k == s_stk);
            #1;
            chk("issue_stk_valid", 64'(stk_valid), 64'(1));
            chk("issue_stk_cmd", 64'(stk_cmd), 64'(icmd));
            chk("issue_stk_data", 64'(stk_data), 64'(idata));
            chk("issue_grant_id", 64'(grant_id), 64'(g));
            chk("issue_req_ready", 64'(req_ready), 64'(0));
            chk("issue_busy", 64'(busy), 64'(1));
            cyc();
        end
        stk_ready = 1'b0;
        rcmd  = bad ? {1'b1, ~icmd[0]} : {1'b1, icmd[0]};
        rdata = DW'($urandom);
        for (int k = 0; k <= dly; k++) begin
            stk_rsp_valid = (k == dly);
            stk_rsp_cmd   = (k == dly) ? rcmd : 2'($urandom);
            stk_rsp_data  = (k == dly) ? rdata : DW'($urandom);
            #1;
            chk("wait_stk_rsp_ready", 64'(stk_rsp_ready), 64'(1));
            chk("wait_stk_valid", 64'(stk_valid), 64'(0));
            chk("wait_rsp_valid", 64'(rsp_valid), 64'(0));
            chk("wait_req_ready", 64'(req_ready), 64'(0));
            cyc();
        end
        stk_rsp_valid = 1'b0;
        exp_rc = '0;
        exp_rd = '0;
        exp_rc[2*g +: 2]   = rcmd;
        exp_rd[DW*g +: DW] = rdata;
        for (int k = 0; k <= s_rsp; k++) begin
            rr    = N'($urandom);
            rr[g] = (k == s_rsp);
            rsp_ready = rr;
            #1;
            chk("resp_rsp_valid", 64'(rsp_valid), 64'(onehot(g)));
            chk("resp_rsp_cmd", 64'(rsp_cmd), 64'(exp_rc));
            chk("resp_rsp_data", 64'(rsp_data), 64'(exp_rd));
            chk("resp_rsp_err", 64'(rsp_err), 64'(bad && (k == 0)));
            chk("resp_stk_rsp_ready", 64'(stk_rsp_ready), 64'(0));
            chk("resp_req_ready", 64'(req_ready), 64'(0));
            cyc();
        end
        rsp_ready = '0;
        req_valid = '0;
        #1;
        chk("done_busy", 64'(busy), 64'(0));
        chk("done_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("done_rsp_err", 64'(rsp_err), 64'(0));
`ifdef STACK_ARB_FIXED_PRIO_EN
        ptr = 0;
`else
        ptr = (g + 1) % N;
`endif
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        chk({tag, "_rsp_cmd"}, 64'(rsp_cmd), 64'(0));
        chk({tag, "_rsp_data"}, 64'(rsp_data), 64'(0));
        chk({tag, "_stk_valid"}, 64'(stk_valid), 64'(0));
        chk({tag, "_stk_cmd"}, 64'(stk_cmd), 64'(0));
        chk({tag, "_stk_data"}, 64'(stk_data), 64'(0));
        chk({tag, "_stk_rsp_ready"}, 64'(stk_rsp_ready), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_grant_id"}, 64'(grant_id), 64'(0));
        chk({tag, "_rsp_err"}, 64'(rsp_err), 64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0]   v;
        logic [CW-1:0]  c;
        logic [DWN-1:0] d;
        int             g;

        // Hand-derived grants, starting from pointer 0.
        //          valid    cmd          data           rr fp stk dly rsp bad
        tbl[0]  = '{4'b1111, 8'b01010101, 32'h11223344, 0, 0, 0, 0, 0, 1'b1};
        tbl[1]  = '{4'b1111, 8'b01010101, 32'hA1B2C3D4, 1, 0, 5, 0, 3, 1'b0};
        tbl[2]  = '{4'b1111, 8'b01010101, 32'h0F1E2D3C, 2, 0, 0, 2, 0, 1'b0};
        tbl[3]  = '{4'b1111, 8'b01010101, 32'h99887766, 3, 0, 1, 0, 1, 1'b0};
        tbl[4]  = '{4'b1111, 8'b01010101, 32'h55AA55AA, 0, 0, 0, 0, 0, 1'b0};
        tbl[5]  = '{4'b0001, 8'b01010101, 32'h000000C3, 0, 0, 0, 1, 0, 1'b0};
        tbl[6]  = '{4'b1111, 8'b01001111, 32'hDEADBEEF, 2, 2, 2, 0, 0, 1'b0};
        tbl[7]  = '{4'b0110, 8'b00000000, 32'h12345678, 1, 1, 0, 0, 2, 1'b1};
        tbl[8]  = '{4'b1001, 8'b00000000, 32'h87654321, 3, 0, 0, 0, 0, 1'b0};
        tbl[9]  = '{4'b1010, 8'b00000000, 32'hCAFEF00D, 1, 1, 1, 1, 1, 1'b0};
        tbl[10] = '{4'b0110, 8'b00001100, 32'h00BB7700, 2, 2, 0, 0, 0, 1'b0};

        rst_n         = 1'b0;
        req_valid     = '0;
        req_cmd       = '0;
        req_data      = '0;
        rsp_ready     = '0;
        stk_ready     = 1'b0;
        stk_rsp_valid = 1'b0;
        stk_rsp_cmd   = '0;
        stk_rsp_data  = '0;
        cyc();
        cyc();
        chk_all_zero("reset");
        rst_n = 1'b1;
        cyc();

        // Single PUSH from requester 0 with a zero-stall stack.
        do_txn(4'b0001, 8'b00000000, 32'h0000005A, 0, 0, 0, 0, 1'b0);

        // Reset while waiting on the stack response; requester 2 is in flight.
        req_valid = 4'b0100;
        req_cmd   = '0;
        req_data  = 32'h00AA0000;
        #1;
        chk("rst_seq_req_ready", 64'(req_ready), 64'(onehot(2)));
        cyc();
        req_valid = '0;
        stk_ready = 1'b1;
        #1;
        chk("rst_seq_stk_data", 64'(stk_data), 64'(8'hAA));
        cyc();
        stk_ready = 1'b0;
        #1;
        chk("rst_seq_stk_rsp_ready", 64'(stk_rsp_ready), 64'(1));
        req_valid = '1;
        req_cmd   = 8'b01010101;
        rst_n     = 1'b0;
        #1;
        chk_all_zero("midrst");
        cyc();
        chk_all_zero("midrst_hold");
        rst_n = 1'b1;
        ptr   = 0;

        // Directed table; first entry also confirms requester 0 wins after reset.
        for (int i = 0; i < 11; i++) begin
`ifdef STACK_ARB_FIXED_PRIO_EN
            g = tbl[i].g_fp;
`else
            g = tbl[i].g_rr;
`endif
            do_txn(tbl[i].v, tbl[i].c, tbl[i].d, g, tbl[i].s_stk, tbl[i].dly,
                   tbl[i].s_rsp, tbl[i].bad);
        end

        // Randomized transactions against the arbitration model.
        for (int i = 0; i < 40; i++) begin
            v = N'($urandom);
            c = CW'($urandom);
            d = DWN'($urandom);
            g = model_winner(v, c, ptr);
            if (g < 0) begin
                req_valid = v;
                req_cmd   = c;
                req_data  = d;
                #1;
                chk("rand_none_req_ready", 64'(req_ready), 64'(0));
                cyc();
                req_valid = '0;
                #1;
                chk("rand_none_busy", 64'(busy), 64'(0));
            end else begin
                do_txn(v, c, d, g, $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
